dmem_ctrl: RTL and testbench

Two-requester access controller for the word-organised, big-endian data memory (SIZE-byte array, negedge word write, read captured on the rising edge of its read strobe). Port A (CPU load/store unit) and port B (DMA/debug) share the memory under round-robin arbitration. The block also provides byte and halfword access: sub-word loads are extracted from the word, and sub-word stores are performed as read-modify-write, because the memory only writes whole words.

---
 rtl/dmem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Two-port (A = load/store unit, B = DMA/debug) round-robin controller for a big-endian word memory,
// with sub-word loads and read-modify-write sub-word stores. Optional bounds check: DMEM_CTRL_BOUNDS_EN.
module dmem_ctrl #(
  parameter logic [31:0] MEM_SIZE = 32'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_size,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_size,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

`ifdef DMEM_CTRL_BOUNDS_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  // Handshake: a requester holds req and its fields stable until its one-cycle ack;
  // ack carries err and rdata, and req must drop in the following cycle.
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic        last_grant;  // 0 = A, 1 = B
  logic        g_port;
  logic        g_we;
  logic [1:0]  g_size;
  logic [1:0]  g_off;
  logic [15:0] g_wdata;

  logic        any_req;
  logic        pick;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        misalign;
  logic        oob;
  logic        sel_bad;

  always_comb begin
    any_req = a_req | b_req;
    if (a_req && b_req) pick = ~last_grant;
    else                pick = b_req & ~a_req;
    sel_we    = pick ? b_we    : a_we;
    sel_size  = pick ? b_size  : a_size;
    sel_addr  = pick ? b_addr  : a_addr;
    sel_wdata = pick ? b_wdata : a_wdata;
    misalign  = ((sel_size == 2'b01) && sel_addr[0]) ||
                (sel_size[1] && (sel_addr[1:0] != 2'b00));
    oob       = ({sel_addr[31:2], 2'b00} >= MEM_SIZE);
    sel_bad   = misalign | (BOUNDS_EN & oob);
  end

  // Big-endian lane extraction, zero-extended and right-justified.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off);
    logic [31:0] r;
    if (size[1]) begin
      r = word;
    end else if (size[0]) begin
      r = off[1] ? {16'h0, word[15:0]} : {16'h0, word[31:16]};
    end else begin
      case (off)
        2'd0:    r = {24'h0, word[31:24]};
        2'd1:    r = {24'h0, word[23:16]};
        2'd2:    r = {24'h0, word[15:8]};
        default: r = {24'h0, word[7:0]};
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                        input logic [1:0] off, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (size[0]) begin
      if (off[1]) r[15:0]  = wd;
      else        r[31:16] = wd;
    end else begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      g_port         <= 1'b0;
      g_we           <= 1'b0;
      g_size         <= 2'b00;
      g_off          <= 2'b00;
      g_wdata        <= 16'h0;
      a_ack          <= 1'b0;
      a_err          <= 1'b0;
      a_rdata        <= 32'h0;
      b_ack          <= 1'b0;
      b_err          <= 1'b0;
      b_rdata        <= 32'h0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      // Response outputs are non-zero only in the DONE cycle.
      a_ack   <= 1'b0;
      a_err   <= 1'b0;
      a_rdata <= 32'h0;
      b_ack   <= 1'b0;
      b_err   <= 1'b0;
      b_rdata <= 32'h0;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant  <= pick;
            g_port      <= pick;
            g_we        <= sel_we;
            g_size      <= sel_size;
            g_off       <= sel_addr[1:0];
            g_wdata     <= sel_wdata[15:0];
            mem_address <= {sel_addr[31:2], 2'b00};
            if (sel_bad) begin
              state <= DONE;
              a_ack <= ~pick;
              a_err <= ~pick;
              b_ack <= pick;
              b_err <= pick;
            end else if (!sel_we || !sel_size[1]) begin
              state    <= RD;
              mem_read <= 1'b1;
            end else begin
              state          <= WR;
              mem_write      <= 1'b1;
              mem_write_data <= sel_wdata;
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          if (!g_we) begin
            state <= DONE;
            a_ack <= ~g_port;
            b_ack <= g_port;
            if (g_port) b_rdata <= extract(mem_read_data, g_size, g_off);
            else        a_rdata <= extract(mem_read_data, g_size, g_off);
          end else begin
            state          <= WR;
            mem_write      <= 1'b1;
            mem_write_data <= merge(mem_read_data, g_size, g_off, g_wdata);
          end
        end
        WR: begin
          mem_write <= 1'b0;
          state     <= DONE;
          a_ack     <= ~g_port;
          b_ack     <= g_port;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench for dmem_ctrl: stimulus pushes expected acks, a monitor pops and compares.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [1:0]  a_size = 0, b_size = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  // Memory model: 256 words, aliasing on address bits above 9.
  logic [31:0] mem [0:255];
  always @(negedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
  always @(posedge mem_read) mem_read_data <= mem[mem_address[9:2]];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int req_cyc_a = 0;
  int req_cyc_b = 0;
  logic prev_a = 0, prev_b = 0;
  logic [37:0] exp_q[$];  // {port, err, latency[3:0], rdata}; latency 0 = not checked

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_read)  rd_pulses++;
    if (mem_write) wr_pulses++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [37:0] e;
    if (rst_n && (a_ack || b_ack)) begin
      chk("ack_onehot", a_ack & b_ack, 0);
      chk("ack_width", (a_ack & prev_a) | (b_ack & prev_b), 0);
      chk("ack_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ack_port", b_ack, e[37]);
        chk("ack_err", b_ack ? b_err : a_err, e[36]);
        chk("ack_rdata", b_ack ? b_rdata : a_rdata, e[31:0]);
        if (e[35:32] != 4'd0)
          chk("ack_latency", (b_ack ? cyc - req_cyc_b : cyc - req_cyc_a) + 1, e[35:32]);
      end
    end
    prev_a = a_ack;
    prev_b = b_ack;
  end

  task automatic do_access(input logic port, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                           input int exp_rd, input int exp_wr);
    int rd0, wr0;
    logic got;
    exp_q.push_back({port, exp_err, 4'(exp_lat), exp_rdata});
    @(posedge clk); #1;
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    if (!port) begin
      a_req = 1; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata; req_cyc_a = cyc;
    end else begin
      b_req = 1; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata; req_cyc_b = cyc;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? b_ack : a_ack;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: port %0d addr %0h got no ack expected ack", port, addr);
    end
    @(posedge clk); #1;
    if (!port) a_req = 0; else b_req = 0;
    chk("mem_read_cycles", rd_pulses - rd0, exp_rd);
    chk("mem_write_cycles", wr_pulses - wr0, exp_wr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic got;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
                          mem_write, mem_read, mem_address[31:0]}, 0);
    chk("reset_wdata", mem_write_data, 0);
    @(negedge clk);
    rst_n = 1;

    // Word store / load
    do_access(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 32'h0, 3, 0, 1);
    do_access(0, 0, 2'b10, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0);
    // Byte stores (read-modify-write) and byte loads
    do_access(0, 1, 2'b10, 32'h20, 32'h11223344, 0, 32'h0, 3, 0, 1);
    do_access(0, 1, 2'b00, 32'h22, 32'h123456AA, 0, 32'h0, 4, 1, 1);
    do_access(0, 0, 2'b10, 32'h20, 32'h0, 0, 32'h1122AA44, 3, 1, 0);
    do_access(0, 0, 2'b00, 32'h21, 32'h0, 0, 32'h00000022, 3, 1, 0);
    do_access(0, 0, 2'b00, 32'h20, 32'h0, 0, 32'h00000011, 3, 1, 0);
    do_access(0, 1, 2'b00, 32'h23, 32'hFFFFFF99, 0, 32'h0, 4, 1, 1);
    do_access(0, 0, 2'b11, 32'h20, 32'h0, 0, 32'h1122AA99, 3, 1, 0);
    // Half store on port B over zero
    do_access(1, 1, 2'b01, 32'h32, 32'h1234BEEF, 0, 32'h0, 4, 1, 1);
    do_access(1, 0, 2'b10, 32'h30, 32'h0, 0, 32'h0000BEEF, 3, 1, 0);
    do_access(1, 0, 2'b01, 32'h30, 32'h0, 0, 32'h00000000, 3, 1, 0);
    do_access(1, 0, 2'b01, 32'h32, 32'h0, 0, 32'h0000BEEF, 3, 1, 0);
    do_access(1, 0, 2'b00, 32'h33, 32'h0, 0, 32'h000000EF, 3, 1, 0);
    // Misaligned accesses: error, memory untouched
    do_access(0, 0, 2'b10, 32'h13, 32'h0, 1, 32'h0, 2, 0, 0);
    do_access(1, 0, 2'b01, 32'h15, 32'h0, 1, 32'h0, 2, 0, 0);
    do_access(0, 1, 2'b10, 32'h12, 32'h55555555, 1, 32'h0, 2, 0, 0);
    do_access(0, 0, 2'b10, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0);
`ifdef DMEM_CTRL_BOUNDS_EN
    do_access(0, 0, 2'b10, 32'h8000, 32'h0, 1, 32'h0, 2, 0, 0);
`else
    do_access(0, 0, 2'b10, 32'h8010, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0);
`endif

    // Round robin with both requests held: A, B, A, B
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 4'd0, 32'hDEADBEEF});
    exp_q.push_back({1'b1, 1'b0, 4'd0, 32'h1122AA99});
    exp_q.push_back({1'b0, 1'b0, 4'd0, 32'hDEADBEEF});
    exp_q.push_back({1'b1, 1'b0, 4'd0, 32'h1122AA99});
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_size = 2'b10; a_addr = 32'h10;
    b_req = 1; b_we = 0; b_size = 2'b10; b_addr = 32'h20;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) n++;
    end
    chk("rr_ack_count", n, 4);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;

    // Reset during the WR cycle of a byte store
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_size = 2'b00; a_addr = 32'h41; a_wdata = 32'h55;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = mem_write;
    end
    chk("rmw_reached_wr", got, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mem_write", mem_write, 0);
    chk("rst_acks", {a_ack, b_ack, a_err, b_err, mem_read}, 0);
    a_we = 0; a_size = 2'b10; a_addr = 32'h40;
    b_req = 1; b_we = 0; b_size = 2'b10; b_addr = 32'h10;
    exp_q.push_back({1'b0, 1'b0, 4'd0, 32'h0});
    repeat (2) @(negedge clk);
    rst_n = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = a_ack | b_ack;
    end
    chk("post_reset_ack_seen", got, 1);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
